alu_sequencer: RTL and testbench

Multi-cycle controller that fronts the processor ALU operations behind a valid/ready request/response handshake. Single-step ops (FWD/ADD/AND/OR) finish in one execute cycle. MUL runs as a fixed 8-step shift-and-add, and SHIFT runs one bit position per cycle. Sits between the control unit and the register-file writeback, so long ops stall issue instead of being combinational.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_datapath.sv | 105 ++++++++++
 rtl/alu_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, shift types, FSM states
// and the fixed multiply step count.
package alu_seq_pkg;

   localparam logic [2:0] OP_FWD   = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_MUL   = 3'b100;
   localparam logic [2:0] OP_SHIFT = 3'b101;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam int unsigned MUL_STEPS = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_seq_datapath.sv
// Operand/accumulator registers and the one-step multiply/shift logic of the
// ALU sequencer; sequenced by load/step strobes from the controller.
module alu_seq_datapath
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [2:0]       aluop,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             err
);

   logic [2:0]         op_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   acc_r;
   logic               zero_r;
   logic [WIDTH-1:0]   sum_s;
   logic [SHAMT_W-1:0] amt_s;
   logic [1:0]         shtype_s;

   // a single bit position of the selected shift; sra replicates the MSB,
   // which never changes across iterations and so stays the original sign
   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                  input logic [1:0] kind);
      logic [WIDTH-1:0] r;
      case (kind)
         SH_SLL:  r = {v[WIDTH-2:0], 1'b0};
         SH_SRL:  r = {1'b0, v[WIDTH-1:1]};
         SH_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
         SH_ROR:  r = {v[0], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   assign sum_s    = data1 + data2;
   assign amt_s    = b_r[SHAMT_W-1:0];
   assign shtype_s = b_r[SHAMT_W+1:SHAMT_W];

   // operand capture on load, one multiply/shift iteration per step
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r   <= OP_FWD;
         a_r    <= {WIDTH{1'b0}};
         b_r    <= {WIDTH{1'b0}};
         acc_r  <= {WIDTH{1'b0}};
         zero_r <= 1'b0;
      end else if (load) begin
         op_r   <= aluop;
         a_r    <= data1;
         b_r    <= data2;
         acc_r  <= {WIDTH{1'b0}};
         zero_r <= (sum_s == {WIDTH{1'b0}});
      end else if (step) begin
         case (op_r)
            OP_MUL: begin
               acc_r <= acc_r + (b_r[0] ? a_r : {WIDTH{1'b0}});
               a_r   <= a_r << 1'b1;
               b_r   <= b_r >> 1'b1;
            end
            OP_SHIFT: begin
               // amount 0 still spends one iteration but leaves DATA1 intact
               if (amt_s != {SHAMT_W{1'b0}}) begin
                  a_r <= shift_one(a_r, shtype_s);
               end else begin
                  a_r <= a_r;
               end
            end
            default: begin
               a_r <= a_r;
            end
         endcase
      end
   end

   // result selection from the current register contents
   always_comb begin
      result = {WIDTH{1'b0}};
      err    = 1'b0;
      case (op_r)
         OP_FWD:   result = a_r;
         OP_ADD:   result = a_r + b_r;
         OP_AND:   result = a_r & b_r;
         OP_OR:    result = a_r | b_r;
         OP_MUL:   result = acc_r;
         OP_SHIFT: result = a_r;
         default: begin
            result = {WIDTH{1'b0}};
            err    = 1'b1;
         end
      endcase
   end

   assign zero = zero_r;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU front end: valid/ready request, N iterations in EXEC,
// registered response held in DONE until the consumer accepts it.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [2:0]       ALUOP,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic             RESP_VALID,
   input  logic             RESP_READY,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             ERR,
   output logic             BUSY
);

   state_t             state_r;
   logic [SHAMT_W-1:0] cnt_r;
   logic [SHAMT_W-1:0] n_s;
   logic [SHAMT_W-1:0] amt_s;
   logic               load_s;
   logic               step_s;
   logic [WIDTH-1:0]   dp_result_s;
   logic               dp_zero_s;
   logic               dp_err_s;

   assign amt_s  = DATA2[SHAMT_W-1:0];
   assign load_s = (state_r == ST_IDLE) && REQ_VALID;
   // the counter's zero pass is the write-back cycle, giving N+1 latency
   assign step_s = (state_r == ST_EXEC) && (cnt_r != {SHAMT_W{1'b0}});

   // iteration count for the request currently offered
   always_comb begin
      n_s = {{(SHAMT_W-1){1'b0}}, 1'b1};
      case (ALUOP)
         OP_MUL: n_s = SHAMT_W'(MUL_STEPS);
         OP_SHIFT: begin
            if (amt_s != {SHAMT_W{1'b0}}) begin
               n_s = amt_s;
            end else begin
               n_s = {{(SHAMT_W-1){1'b0}}, 1'b1};
            end
         end
         default: n_s = {{(SHAMT_W-1){1'b0}}, 1'b1};
      endcase
   end

   alu_seq_datapath #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_datapath (
      .clk    (CLK),
      .rst    (RESET),
      .load   (load_s),
      .step   (step_s),
      .aluop  (ALUOP),
      .data1  (DATA1),
      .data2  (DATA2),
      .result (dp_result_s),
      .zero   (dp_zero_s),
      .err    (dp_err_s)
   );

   // control FSM with registered handshake and response outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {SHAMT_W{1'b0}};
         REQ_READY  <= 1'b1;
         RESP_VALID <= 1'b0;
         RESULT     <= {WIDTH{1'b0}};
         ZERO       <= 1'b0;
         ERR        <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (REQ_VALID) begin
                  state_r   <= ST_EXEC;
                  cnt_r     <= n_s;
                  REQ_READY <= 1'b0;
                  BUSY      <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (cnt_r == {SHAMT_W{1'b0}}) begin
                  state_r    <= ST_DONE;
                  RESULT     <= dp_result_s;
                  ZERO       <= dp_zero_s;
                  ERR        <= dp_err_s;
                  RESP_VALID <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               if (RESP_READY) begin
                  state_r    <= ST_IDLE;
                  RESP_VALID <= 1'b0;
                  REQ_READY  <= 1'b1;
                  BUSY       <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= {SHAMT_W{1'b0}};
               REQ_READY  <= 1'b1;
               RESP_VALID <= 1'b0;
               BUSY       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes reference-model results,
// monitor pops and compares whenever a response is presented.
module tb_alu_sequencer;

   logic       CLK;
   logic       RESET;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic [2:0] ALUOP;
   logic [7:0] DATA1;
   logic [7:0] DATA2;
   logic       RESP_VALID;
   logic       RESP_READY;
   logic [7:0] RESULT;
   logic       ZERO;
   logic       ERR;
   logic       BUSY;

   typedef struct {
      logic [7:0] res;
      logic       z;
      logic       e;
      int         lat;
      int         acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   bp_left  = 0;
   bit   rand_rr  = 1'b0;
   bit   prev_valid = 1'b0;
   bit   in_resp    = 1'b0;

   alu_sequencer #(.WIDTH(8), .SHAMT_W(4)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .REQ_VALID  (REQ_VALID),
      .REQ_READY  (REQ_READY),
      .ALUOP      (ALUOP),
      .DATA1      (DATA1),
      .DATA2      (DATA2),
      .RESP_VALID (RESP_VALID),
      .RESP_READY (RESP_READY),
      .RESULT     (RESULT),
      .ZERO       (ZERO),
      .ERR        (ERR),
      .BUSY       (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // reference behaviour written straight from the operation definitions
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t              e;
      logic signed [15:0] p;
      logic signed [7:0]  sa;
      logic [15:0]        dbl;
      logic [7:0]         s;
      int                 amt;
      int                 n;
      s     = a + b;
      e.z   = (s == 8'h00);
      e.e   = 1'b0;
      e.res = 8'h00;
      e.acc_cyc = 0;
      n     = 1;
      amt   = int'(b[3:0]);
      case (op)
         3'd0: e.res = a;
         3'd1: e.res = a + b;
         3'd2: e.res = a & b;
         3'd3: e.res = a | b;
         3'd4: begin
            p     = $signed(a) * $signed(b);
            e.res = p[7:0];
            n     = 8;
         end
         3'd5: begin
            n = (amt == 0) ? 1 : amt;
            case (b[5:4])
               2'd0: e.res = a << amt;
               2'd1: e.res = a >> amt;
               2'd2: begin
                  sa    = a;
                  e.res = sa >>> amt;
               end
               default: begin
                  dbl   = {a, a} >> (amt % 8);
                  e.res = dbl[7:0];
               end
            endcase
         end
         default: e.e = 1'b1;
      endcase
      e.lat = n + 1;
      return e;
   endfunction

   // offer a request, hold it until accepted, then log the expectation
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   n = 0;
      @(negedge CLK);
      REQ_VALID = 1'b1;
      ALUOP     = op;
      DATA1     = a;
      DATA2     = b;
      while (!REQ_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (!REQ_READY) begin
         chk("req_accept_timeout", 32'd0, 32'd1);
         REQ_VALID = 1'b0;
      end else begin
         @(negedge CLK);
         e         = model(op, a, b);
         e.acc_cyc = cyc;
         exp_q.push_back(e);
         REQ_VALID = 1'b0;
      end
   endtask

   // consumer side: optional forced backpressure, otherwise random or always-ready
   initial begin
      RESP_READY = 1'b1;
      forever begin
         @(negedge CLK);
         if (RESP_VALID && bp_left > 0) begin
            RESP_READY = 1'b0;
            bp_left--;
         end else if (rand_rr) begin
            RESP_READY = 1'($urandom_range(0, 1));
         end else begin
            RESP_READY = 1'b1;
         end
      end
   end

   // monitor: pop on each new response and verify it is held while pending
   initial begin
      forever begin
         @(negedge CLK);
         if (RESET) begin
            prev_valid = 1'b0;
            in_resp    = 1'b0;
         end else begin
            chk("req_ready_vs_busy", {31'd0, REQ_READY}, {31'd0, ~BUSY});
            if (RESP_VALID && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", 32'd1, 32'd0);
                  in_resp = 1'b0;
               end else begin
                  cur     = exp_q.pop_front();
                  in_resp = 1'b1;
                  chk("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
               end
            end
            if (RESP_VALID && in_resp) begin
               chk("result", {24'd0, RESULT}, {24'd0, cur.res});
               chk("zero",   {31'd0, ZERO},   {31'd0, cur.z});
               chk("err",    {31'd0, ERR},    {31'd0, cur.e});
               chk("req_ready_in_done", {31'd0, REQ_READY}, 32'd0);
            end
            if (!RESP_VALID && prev_valid) begin
               chk("req_ready_after_hs", {31'd0, REQ_READY}, 32'd1);
            end
            prev_valid = RESP_VALID;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] op;
      logic [7:0] d2;
      int         n;
      RESET     = 1'b1;
      REQ_VALID = 1'b0;
      ALUOP     = 3'b000;
      DATA1     = 8'h00;
      DATA2     = 8'h00;
      repeat (3) @(negedge CLK);
      chk("rst_req_ready",  {31'd0, REQ_READY},  32'd1);
      chk("rst_resp_valid", {31'd0, RESP_VALID}, 32'd0);
      chk("rst_result",     {24'd0, RESULT},     32'd0);
      chk("rst_zero",       {31'd0, ZERO},       32'd0);
      chk("rst_err",        {31'd0, ERR},        32'd0);
      chk("rst_busy",       {31'd0, BUSY},       32'd0);
      RESET = 1'b0;

      // directed cases from the operation table and shift corner amounts
      issue(3'b001, 8'h05, 8'hFB);
      issue(3'b100, 8'hFD, 8'h07);
      issue(3'b101, 8'h90, 8'h23);
      issue(3'b101, 8'h81, 8'h31);
      issue(3'b101, 8'h5A, 8'h00);
      issue(3'b111, 8'h12, 8'h34);
      issue(3'b001, 8'h12, 8'h34);
      issue(3'b101, 8'hB7, 8'h09);
      issue(3'b101, 8'hB7, 8'h1F);
      issue(3'b101, 8'hB7, 8'h2C);
      issue(3'b101, 8'hB7, 8'h38);
      issue(3'b000, 8'h00, 8'h00);
      issue(3'b010, 8'hF0, 8'h3C);
      issue(3'b011, 8'hF0, 8'h0C);

      // backpressure: second request waits behind a stalled response
      n = 0;
      while ((exp_q.size() != 0 || RESP_VALID) && n < 500) begin
         @(negedge CLK);
         n++;
      end
      bp_left = 5;
      issue(3'b001, 8'h40, 8'h33);
      issue(3'b100, 8'h0B, 8'hF6);

      // reset in the middle of a multiply: no response may follow
      n = 0;
      while ((exp_q.size() != 0 || RESP_VALID) && n < 500) begin
         @(negedge CLK);
         n++;
      end
      issue(3'b100, 8'h35, 8'h17);
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      exp_q.delete();
      chk("midrst_req_ready",  {31'd0, REQ_READY},  32'd1);
      chk("midrst_resp_valid", {31'd0, RESP_VALID}, 32'd0);
      chk("midrst_result",     {24'd0, RESULT},     32'd0);
      chk("midrst_busy",       {31'd0, BUSY},       32'd0);
      RESET = 1'b0;
      repeat (15) @(negedge CLK);

      // randomized traffic with random consumer stalls
      rand_rr = 1'b1;
      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         d2 = 8'($urandom);
         if (i % 4 == 0) op = 3'b101;
         issue(op, 8'($urandom), d2);
      end

      n = 0;
      while ((exp_q.size() != 0 || RESP_VALID) && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
